multi_rate_tick_gen: RTL and testbench

//  Synthesizable, parametrised generator of multi-rate timing from one clock. Per channel it

---
 rtl/multi_rate_tick_gen.sv | 148 ++++++++++++++
 tb/tb_multi_rate_tick_gen.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_rate_tick_gen.sv
// Multi-rate clock-enable generator: per-channel tick and phase outputs with runtime
// divisor updates landing on period boundaries, all gated by a bounded run timer.
module multi_rate_tick_gen #(
    parameter int                      NUM_CH  = 3,
    parameter int                      DIV_W   = 16,
    parameter logic [NUM_CH*DIV_W-1:0] DEF_DIV = {16'd1000, 16'd100, 16'd1},
    parameter int                      RUN_W   = 32,
    localparam int                     CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              cfg_valid,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic              cfg_ready,
    input  logic              sync,
    input  logic              run_start,
    input  logic [RUN_W-1:0]  run_len,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] phase,
    output logic              running,
    output logic              done
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]        state_q;
    logic [RUN_W-1:0]  rem_q;
    logic              done_q;

    logic [DIV_W-1:0]  cnt_q    [NUM_CH];
    logic [DIV_W-1:0]  div_q    [NUM_CH];
    logic [DIV_W-1:0]  shadow_q [NUM_CH];
    logic [NUM_CH-1:0] pending_q;
    logic [NUM_CH-1:0] tick_q;
    logic [NUM_CH-1:0] phase_q;

    logic [NUM_CH-1:0] active;
    logic [NUM_CH-1:0] wrap;
    logic [NUM_CH-1:0] wr_sel;
    logic              run_end;
    logic              sync_now;

    // A zero divisor behaves as divide-by-one.
    function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
        return (d == '0) ? DIV_W'(1) : d;
    endfunction

    assign running = (state_q == S_RUN);
    assign done    = done_q;
    assign tick    = tick_q;
    assign phase   = phase_q;

    always_comb begin
        run_end   = running && (rem_q == RUN_W'(1));
        sync_now  = sync && running;
        cfg_ready = 1'b1;
        active    = '0;
        wrap      = '0;
        wr_sel    = '0;
        // Out-of-range channel numbers match nothing, so they stay ready and are dropped.
        for (int i = 0; i < NUM_CH; i++) begin
            active[i] = running && ch_en[i];
            wrap[i]   = active[i] && (cnt_q[i] == eff_div(div_q[i]) - DIV_W'(1));
            if ((cfg_ch == CH_W'(i)) && pending_q[i]) begin
                cfg_ready = 1'b0;
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            wr_sel[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
        end
    end

    // Run timer: IDLE -> RUN for exactly run_len cycles, done pulses once at the end.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (run_start) begin
                        if (run_len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            rem_q   <= run_len;
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    rem_q <= rem_q - RUN_W'(1);
                    if (rem_q == RUN_W'(1)) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Per-channel counters and divisor update; an active channel only swaps divisor at a wrap
    // so no period is ever truncated or stretched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_q    <= '0;
            phase_q   <= '0;
            pending_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
                div_q[i] <= DEF_DIV[i*DIV_W +: DIV_W];
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!active[i] || run_end || sync_now) begin
                    cnt_q[i]   <= '0;
                    tick_q[i]  <= 1'b0;
                    phase_q[i] <= 1'b0;
                end else if (wrap[i]) begin
                    cnt_q[i]   <= '0;
                    tick_q[i]  <= 1'b1;
                    phase_q[i] <= ~phase_q[i];
                end else begin
                    cnt_q[i]   <= cnt_q[i] + DIV_W'(1);
                    tick_q[i]  <= 1'b0;
                end

                if (wr_sel[i]) begin
                    if (active[i] && !sync_now) begin
                        shadow_q[i]  <= cfg_div;
                        pending_q[i] <= 1'b1;
                    end else begin
                        div_q[i] <= cfg_div;
                    end
                end else if (pending_q[i] && (wrap[i] || sync_now || !active[i])) begin
                    div_q[i]     <= shadow_q[i];
                    pending_q[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_rate_tick_gen.sv
// Bench for multi_rate_tick_gen: randomized runs compared against a tick-schedule model built
// from elapsed-time modulo arithmetic, plus directed checks of the documented scenarios.
module tb_multi_rate_tick_gen;

    localparam int NEVER = 32'h3fff_ffff;
    localparam int MAXT  = 4200;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic [2:0]  ch_en     = 3'b000;
    logic        cfg_valid = 1'b0;
    logic [1:0]  cfg_ch    = 2'd0;
    logic [15:0] cfg_div   = 16'd0;
    logic        cfg_ready;
    logic        sync      = 1'b0;
    logic        run_start = 1'b0;
    logic [31:0] run_len   = 32'd0;
    logic [2:0]  tick;
    logic [2:0]  phase;
    logic        running;
    logic        done;

    int checks   = 0;
    int failures = 0;

    int div_m [3];
    bit exp_tk [3][MAXT];
    bit exp_ph [3][MAXT];
    bit exp_pd [3][MAXT];

    int    bad_total, bad_t, bad_ch;
    string bad_sig;
    int    got_pulses [3];
    int    got_first  [3];
    int    got_second [3];
    int    run_hi, done_cnt, rdy_low;
    int    ref_t;

    multi_rate_tick_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ch_en     (ch_en),
        .cfg_valid (cfg_valid),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .sync      (sync),
        .run_start (run_start),
        .run_len   (run_len),
        .tick      (tick),
        .phase     (phase),
        .running   (running),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic int eff(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic note(input int t, input int ch, input string s);
        bad_total++;
        if (bad_t < 0) begin
            bad_t   = t;
            bad_ch  = ch;
            bad_sig = s;
        end
    endtask

    // One run of len cycles. t counts clock edges from the start edge (t=0). The model says a
    // channel ticks when the time since its last restart point is a multiple of its period;
    // restarts happen whenever it is idle, disabled or synced, and after a deferred divisor swap.
    task automatic do_run(input int len, input logic [2:0] en0, input int en_t, input int en_ch,
                          input logic en_val, input int sync_t, input int wr_t, input int wr_ch,
                          input int wr_div);
        int a  [3];
        int np [3];
        bit pend [3];
        bit ph [3];
        bit act, tk, snc, wr;
        for (int i = 0; i < 3; i++) begin
            a[i] = 0; np[i] = 0; pend[i] = 1'b0; ph[i] = 1'b0;
        end
        for (int t = 0; t <= len + 2; t++) begin
            snc = (t == sync_t) && (t >= 1) && (t <= len);
            for (int i = 0; i < 3; i++) begin
                act = (t >= 1) && (t <= len) && (((i == en_ch) && (t >= en_t)) ? en_val : en0[i]);
                wr  = (t == wr_t) && (i == wr_ch) && !pend[i];
                tk  = 1'b0;
                if (!act || (t == len) || snc) begin
                    a[i] = t; ph[i] = 1'b0;
                end else if ((t - a[i]) % div_m[i] == 0) begin
                    tk = 1'b1; ph[i] = !ph[i];
                end
                if (wr) begin
                    if (act && !snc) begin np[i] = eff(wr_div); pend[i] = 1'b1; end
                    else div_m[i] = eff(wr_div);
                end else if (pend[i] && (tk || snc || !act)) begin
                    div_m[i] = np[i]; pend[i] = 1'b0; a[i] = t;
                end
                exp_tk[i][t] = tk; exp_ph[i][t] = ph[i]; exp_pd[i][t] = pend[i];
            end
        end

        bad_total = 0; bad_t = -1; bad_ch = -1; bad_sig = "none";
        run_hi = 0; done_cnt = 0; rdy_low = 0;
        for (int i = 0; i < 3; i++) begin
            got_pulses[i] = 0; got_first[i] = -1; got_second[i] = -1;
        end
        ch_en = en0; cfg_ch = 2'(wr_ch); cfg_div = 16'(wr_div);
        run_len = 32'(len); run_start = 1'b1;
        for (int t = 0; t <= len + 2; t++) begin
            if (t > 0) begin
                for (int i = 0; i < 3; i++) ch_en[i] = ((i == en_ch) && (t >= en_t)) ? en_val : en0[i];
                sync      = (t == sync_t);
                cfg_valid = (t == wr_t);
                run_start = (t == len / 2);
            end
            step();
            run_start = 1'b0; sync = 1'b0; cfg_valid = 1'b0;
            for (int i = 0; i < 3; i++) begin
                if (tick[i] !== exp_tk[i][t]) note(t, i, "tick");
                if (phase[i] !== exp_ph[i][t]) note(t, i, "phase");
                if (tick[i] === 1'b1) begin
                    got_pulses[i]++;
                    if (t > ref_t) begin
                        if (got_first[i] < 0) got_first[i] = t;
                        else if (got_second[i] < 0) got_second[i] = t;
                    end
                end
            end
            if (running !== (t < len)) note(t, -1, "running");
            if (done !== (t == len)) note(t, -1, "done");
            if (running === 1'b1) run_hi++;
            if (done === 1'b1) done_cnt++;
            if (wr_ch < 3) begin
                if (cfg_ready !== !exp_pd[wr_ch][t]) note(t, wr_ch, "cfg_ready");
                if (cfg_ready === 1'b0) rdy_low++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ch_en = 3'b111; run_start = 1'b1; run_len = 32'd50;
        repeat (3) step();
        checks++; if (tick !== 3'b000) begin failures++; $display("FAIL reset_tick got=%b exp=000", tick); end
        checks++; if (phase !== 3'b000) begin failures++; $display("FAIL reset_phase got=%b exp=000", phase); end
        checks++; if (running !== 1'b0) begin failures++; $display("FAIL reset_running got=%b exp=0", running); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        for (int c = 0; c < 3; c++) begin
            cfg_ch = 2'(c); #1;
            checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_ready ch=%0d got=%b exp=1", c, cfg_ready); end
        end
        run_start = 1'b0; rst_n = 1'b1;
        step();
        div_m[0] = 1; div_m[1] = 100; div_m[2] = 1000;
    endtask

    task automatic test_run_defaults();
        int len;
        len = $urandom_range(2000, 3500);
        ref_t = 0;
        do_run(len, 3'b111, NEVER, 0, 1'b0, NEVER, NEVER, 0, 0);
        checks++; if (bad_total !== 0) begin failures++; $display("FAIL defaults_model got=%0d mismatches exp=0 (first t=%0d ch=%0d %s)", bad_total, bad_t, bad_ch, bad_sig); end
        checks++; if (got_pulses[0] !== len - 1) begin failures++; $display("FAIL defaults_tick0_high got=%0d exp=%0d", got_pulses[0], len - 1); end
        checks++; if (got_pulses[1] !== (len - 1) / 100) begin failures++; $display("FAIL defaults_tick1_pulses got=%0d exp=%0d", got_pulses[1], (len - 1) / 100); end
        checks++; if (got_pulses[2] !== (len - 1) / 1000) begin failures++; $display("FAIL defaults_tick2_pulses got=%0d exp=%0d", got_pulses[2], (len - 1) / 1000); end
        checks++; if (run_hi !== len) begin failures++; $display("FAIL defaults_running_cycles got=%0d exp=%0d", run_hi, len); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL defaults_done_pulses got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_run_zero();
        int hi;
        ch_en = 3'b111; run_len = 32'd0; run_start = 1'b1;
        step();
        run_start = 1'b0;
        checks++; if (running !== 1'b0) begin failures++; $display("FAIL zero_running got=%b exp=0", running); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL zero_done_first got=%b exp=1", done); end
        sync = 1'b1;
        step();
        sync = 1'b0;
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL zero_done_second got=%b exp=0", done); end
        hi = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (tick !== 3'b000 || phase !== 3'b000 || running !== 1'b0 || done !== 1'b0) hi++;
        end
        checks++; if (hi !== 0) begin failures++; $display("FAIL zero_quiet got=%0d active_cycles exp=0", hi); end
    endtask

    task automatic test_sync();
        int len, s;
        len = $urandom_range(2600, 3200);
        s = $urandom_range(1200, 1500);
        ref_t = s;
        do_run(len, 3'b111, NEVER, 0, 1'b0, s, NEVER, 0, 0);
        checks++; if (bad_total !== 0) begin failures++; $display("FAIL sync_model got=%0d mismatches exp=0 (first t=%0d ch=%0d %s)", bad_total, bad_t, bad_ch, bad_sig); end
        checks++; if (got_first[0] !== s + 1) begin failures++; $display("FAIL sync_ch0_next got=%0d exp=%0d", got_first[0], s + 1); end
        checks++; if (got_first[1] !== s + 100) begin failures++; $display("FAIL sync_ch1_next got=%0d exp=%0d", got_first[1], s + 100); end
        checks++; if (got_first[2] !== s + 1000) begin failures++; $display("FAIL sync_ch2_next got=%0d exp=%0d", got_first[2], s + 1000); end
    endtask

    task automatic test_enable();
        int len;
        len = $urandom_range(2600, 3000);
        ref_t = 499;
        do_run(len, 3'b011, 500, 2, 1'b1, NEVER, NEVER, 0, 0);
        checks++; if (bad_total !== 0) begin failures++; $display("FAIL enable_model got=%0d mismatches exp=0 (first t=%0d ch=%0d %s)", bad_total, bad_t, bad_ch, bad_sig); end
        checks++; if (got_first[2] !== 1499) begin failures++; $display("FAIL enable_first_tick2 got=%0d exp=1499", got_first[2]); end
        checks++; if (got_second[2] !== 2499) begin failures++; $display("FAIL enable_second_tick2 got=%0d exp=2499", got_second[2]); end
    endtask

    task automatic test_cfg_midperiod();
        int w;
        w = $urandom_range(120, 180);
        ref_t = w;
        do_run(1500, 3'b111, NEVER, 0, 1'b0, NEVER, w, 1, 10);
        checks++; if (bad_total !== 0) begin failures++; $display("FAIL cfg_model got=%0d mismatches exp=0 (first t=%0d ch=%0d %s)", bad_total, bad_t, bad_ch, bad_sig); end
        checks++; if (got_first[1] !== 200) begin failures++; $display("FAIL cfg_old_period_end got=%0d exp=200", got_first[1]); end
        checks++; if (got_second[1] !== 210) begin failures++; $display("FAIL cfg_new_period got=%0d exp=210", got_second[1]); end
        checks++; if (rdy_low !== 200 - w) begin failures++; $display("FAIL cfg_ready_low_cycles got=%0d exp=%0d", rdy_low, 200 - w); end
    endtask

    task automatic test_cfg_out_of_range();
        cfg_ch = 2'd3; cfg_div = 16'd2; cfg_valid = 1'b1;
        #1;
        checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL oor_ready got=%b exp=1", cfg_ready); end
        step();
        cfg_valid = 1'b0;
        ref_t = 0;
        do_run(1200, 3'b111, NEVER, 0, 1'b0, NEVER, 300, 3, 2);
        checks++; if (bad_total !== 0) begin failures++; $display("FAIL oor_model got=%0d mismatches exp=0 (first t=%0d ch=%0d %s)", bad_total, bad_t, bad_ch, bad_sig); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 3; it++) begin
            int len, ch, d, en_ch, en_t, sync_t, wr_t, wr_ch, wr_div;
            logic [2:0] en0;
            ch = $urandom_range(0, 2); d = $urandom_range(0, 30);
            cfg_ch = 2'(ch); cfg_div = 16'(d); cfg_valid = 1'b1;
            step();
            cfg_valid = 1'b0;
            div_m[ch] = eff(d);
            len    = $urandom_range(1500, 2500);
            en0    = 3'($urandom_range(0, 7));
            en_ch  = $urandom_range(0, 2);
            en_t   = ($urandom_range(0, 1) == 1) ? $urandom_range(10, len - 10) : NEVER;
            sync_t = ($urandom_range(0, 1) == 1) ? $urandom_range(10, len) : NEVER;
            wr_ch  = $urandom_range(0, 2);
            wr_div = $urandom_range(1, 30);
            wr_t   = $urandom_range(20, len - 1100);
            ref_t  = 0;
            do_run(len, en0, en_t, en_ch, !en0[en_ch], sync_t, wr_t, wr_ch, wr_div);
            checks++; if (bad_total !== 0) begin failures++; $display("FAIL random_model it=%0d got=%0d mismatches exp=0 (first t=%0d ch=%0d %s)", it, bad_total, bad_t, bad_ch, bad_sig); end
        end
    endtask

    task automatic test_reset_mid_run();
        int seen;
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 16'd7;
        step();
        cfg_ch = 2'd2; cfg_div = 16'd5;
        step();
        cfg_valid = 1'b0;
        ch_en = 3'b111; run_len = 32'd3000; run_start = 1'b1;
        step();
        run_start = 1'b0;
        repeat (50) step();
        rst_n = 1'b0;
        step();
        checks++; if (tick !== 3'b000) begin failures++; $display("FAIL rstrun_tick got=%b exp=000", tick); end
        checks++; if (phase !== 3'b000) begin failures++; $display("FAIL rstrun_phase got=%b exp=000", phase); end
        checks++; if (running !== 1'b0) begin failures++; $display("FAIL rstrun_running got=%b exp=0", running); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rstrun_done got=%b exp=0", done); end
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (done !== 1'b0 || running !== 1'b0 || tick !== 3'b000) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL rstrun_quiet got=%0d active_cycles exp=0", seen); end
        div_m[0] = 1; div_m[1] = 100; div_m[2] = 1000;
        ref_t = 0;
        do_run(1200, 3'b111, NEVER, 0, 1'b0, NEVER, NEVER, 0, 0);
        checks++; if (bad_total !== 0) begin failures++; $display("FAIL rstrun_model got=%0d mismatches exp=0 (first t=%0d ch=%0d %s)", bad_total, bad_t, bad_ch, bad_sig); end
        checks++; if (got_first[1] !== 100) begin failures++; $display("FAIL rstrun_div1_default got=%0d exp=100", got_first[1]); end
        checks++; if (got_first[2] !== 1000) begin failures++; $display("FAIL rstrun_div2_default got=%0d exp=1000", got_first[2]); end
    endtask

    initial begin
        test_reset();
        test_run_defaults();
        test_run_zero();
        test_sync();
        test_enable();
        test_cfg_midperiod();
        test_cfg_out_of_range();
        test_random();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
